// File: rtl/tone_pkg.sv
// Shared constants for the note tone player: note/half-period widths, the
// C4..C5 half-period table for a 27 MHz clock, and the player state encoding.
package tone_pkg;

  localparam int NOTE_W   = 3;
  localparam int HALF_W   = 16;
  localparam int NOTE_NUM = 1 << NOTE_W;

  // Half-period in clk cycles for each note index (0=C4 ... 7=C5).
  localparam logic [HALF_W-1:0] HALF_PERIOD [NOTE_NUM] = '{
    16'd51600, 16'd45971, 16'd40955, 16'd38656,
    16'd34439, 16'd30682, 16'd27334, 16'd25800
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/tone_divider.sv
// Square-wave divider: counts a phase counter up to half-1 and toggles sq.
// clr restarts the phase and loads sq with en, so a restart with en=1 begins high.
module tone_divider
  import tone_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [HALF_W-1:0] half,
  output logic              sq
);

  logic [HALF_W-1:0] phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      sq    <= 1'b0;
    end else if (clr) begin
      phase <= '0;
      sq    <= en;
    end else if (en) begin
      if (phase == half - 1'b1) begin
        phase <= '0;
        sq    <= ~sq;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_tone_player.sv
// Plays one note per debounced button press as a square wave for DUR_CYCLES,
// then a GAP_CYCLES silence; one press arriving mid-note is held as pending.
module note_tone_player
  import tone_pkg::*;
#(
  parameter int DUR_CYCLES = 6_750_000,
  parameter int GAP_CYCLES = 1_350_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_stable,
  input  logic [NOTE_W-1:0] note_sel,
  input  logic              stop,
  output logic              tone_out,
  output logic              busy,
  output logic [NOTE_W-1:0] cur_note,
  output logic              pending
);

  localparam int DW = (DUR_CYCLES > 1) ? $clog2(DUR_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DUR_LAST = DW'(DUR_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t            state, state_n;
  logic              btn_q;
  logic              press;
  logic [DW-1:0]     dur_cnt, dur_n;
  logic [GW-1:0]     gap_cnt, gap_n;
  logic [NOTE_W-1:0] note_n;
  logic [NOTE_W-1:0] pend_note, pnote_n;
  logic              pend_n;
  logic              div_en, div_clr;

  assign press = btn_stable & ~btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      btn_q     <= 1'b0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      cur_note  <= '0;
      pend_note <= '0;
      pending   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      btn_q     <= btn_stable;
      dur_cnt   <= dur_n;
      gap_cnt   <= gap_n;
      cur_note  <= note_n;
      pend_note <= pnote_n;
      pending   <= pend_n;
      busy      <= (state_n != IDLE);
    end
  end

  // Divider is held cleared (silent) by default; starting a note uses clr+en
  // so the first level is high, normal playback uses en alone.
  always_comb begin
    state_n = state;
    dur_n   = dur_cnt;
    gap_n   = gap_cnt;
    note_n  = cur_note;
    pend_n  = pending;
    pnote_n = pend_note;
    div_en  = 1'b0;
    div_clr = 1'b1;

    if (stop) begin
      state_n = IDLE;
      dur_n   = '0;
      gap_n   = '0;
      pend_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (press) begin
            state_n = PLAY;
            note_n  = note_sel;
            dur_n   = '0;
            div_en  = 1'b1;
          end
        end
        PLAY: begin
          if (dur_cnt == DUR_LAST) begin
            state_n = GAP;
            dur_n   = '0;
            gap_n   = '0;
          end else begin
            dur_n   = dur_cnt + 1'b1;
            div_en  = 1'b1;
            div_clr = 1'b0;
          end
          if (press) begin
            pend_n  = 1'b1;
            pnote_n = note_sel;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_n = '0;
            dur_n = '0;
            if (pending) begin
              state_n = PLAY;
              note_n  = pend_note;
              div_en  = 1'b1;
              pend_n  = press;
              if (press) pnote_n = note_sel;
            end else if (press) begin
              state_n = PLAY;
              note_n  = note_sel;
              div_en  = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            gap_n = gap_cnt + 1'b1;
            if (press) begin
              pend_n  = 1'b1;
              pnote_n = note_sel;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  tone_divider u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (div_clr),
    .half (HALF_PERIOD[cur_note]),
    .sq   (tone_out)
  );

endmodule

// File: tb/tb_note_tone_player.sv
// Directed bench: a short-duration instance driven from a vector table for the
// queueing/abort logic, and a long-duration instance for the waveform timing.
module tb_note_tone_player;

  localparam int S_DUR = 40;
  localparam int S_GAP = 8;
  localparam int L_DUR = 51600;
  localparam int L_GAP = 5;

  typedef struct {
    logic       rst;
    logic       btn;
    logic [2:0] sel;
    logic       stop;
    int         cycles;
    logic       tone;
    logic       busy;
    logic [2:0] note;
    logic       pend;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_s = 1'b0, stop_s = 1'b0;
  logic [2:0] sel_s = 3'd0;
  logic       tone_s, busy_s, pend_s;
  logic [2:0] note_s;
  logic       btn_l = 1'b0, stop_l = 1'b0;
  logic [2:0] sel_l = 3'd0;
  logic       tone_l, busy_l, pend_l;
  logic [2:0] note_l;

  int   tests  = 0;
  int   fails  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  note_tone_player #(.DUR_CYCLES(S_DUR), .GAP_CYCLES(S_GAP)) dut_s (
    .clk(clk), .rst(rst), .btn_stable(btn_s), .note_sel(sel_s), .stop(stop_s),
    .tone_out(tone_s), .busy(busy_s), .cur_note(note_s), .pending(pend_s)
  );

  note_tone_player #(.DUR_CYCLES(L_DUR), .GAP_CYCLES(L_GAP)) dut_l (
    .clk(clk), .rst(rst), .btn_stable(btn_l), .note_sel(sel_l), .stop(stop_l),
    .tone_out(tone_l), .busy(busy_l), .cur_note(note_l), .pending(pend_l)
  );

  task automatic addVec(input logic r, input logic b, input logic [2:0] s,
                        input logic st, input int n, input logic t, input logic bz,
                        input logic [2:0] nt, input logic p, input string nm);
    vec_t v;
    v = '{rst: r, btn: b, sel: s, stop: st, cycles: n, tone: t, busy: bz,
          note: nt, pend: p, name: nm};
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string nm, input logic at, input logic ab,
                             input logic [2:0] an, input logic ap, input logic et,
                             input logic eb, input logic [2:0] en, input logic ep);
    tests += 4;
    if (at !== et) begin
      fails++;
      $display("[TB] FAIL %s tone_out: got %b expected %b", nm, at, et);
    end
    if (ab !== eb) begin
      fails++;
      $display("[TB] FAIL %s busy: got %b expected %b", nm, ab, eb);
    end
    if (an !== en) begin
      fails++;
      $display("[TB] FAIL %s cur_note: got %0d expected %0d", nm, an, en);
    end
    if (ap !== ep) begin
      fails++;
      $display("[TB] FAIL %s pending: got %b expected %b", nm, ap, ep);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst    = v.rst;
    btn_s  = v.btn;
    sel_s  = v.sel;
    stop_s = v.stop;
    repeat (v.cycles) @(posedge clk);
    #1;
    checkOutput(v.name, tone_s, busy_s, note_s, pend_s, v.tone, v.busy, v.note, v.pend);
  endtask

  initial begin
    //     rst   btn   sel   stop  n   tone  busy  note  pend
    addVec(1'b1, 1'b0, 3'd0, 1'b0, 2,  1'b0, 1'b0, 3'd0, 1'b0, "reset");
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1,  1'b0, 1'b0, 3'd0, 1'b0, "idle");
    addVec(1'b0, 1'b1, 3'd2, 1'b0, 1,  1'b1, 1'b1, 3'd2, 1'b0, "press_n2");
    addVec(1'b0, 1'b1, 3'd5, 1'b0, 10, 1'b1, 1'b1, 3'd2, 1'b0, "held_no_queue");
    addVec(1'b0, 1'b0, 3'd5, 1'b0, 1,  1'b1, 1'b1, 3'd2, 1'b0, "release");
    addVec(1'b0, 1'b1, 3'd4, 1'b0, 1,  1'b1, 1'b1, 3'd2, 1'b1, "queue_n4");
    addVec(1'b0, 1'b1, 3'd4, 1'b0, 27, 1'b1, 1'b1, 3'd2, 1'b1, "play_last");
    addVec(1'b0, 1'b1, 3'd4, 1'b0, 1,  1'b0, 1'b1, 3'd2, 1'b1, "gap_enter");
    addVec(1'b0, 1'b1, 3'd4, 1'b0, 7,  1'b0, 1'b1, 3'd2, 1'b1, "gap_last");
    addVec(1'b0, 1'b1, 3'd4, 1'b0, 1,  1'b1, 1'b1, 3'd4, 1'b0, "queued_plays");
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1,  1'b1, 1'b1, 3'd4, 1'b0, "ovw_rel1");
    addVec(1'b0, 1'b1, 3'd1, 1'b0, 1,  1'b1, 1'b1, 3'd4, 1'b1, "ovw_n1");
    addVec(1'b0, 1'b0, 3'd1, 1'b0, 1,  1'b1, 1'b1, 3'd4, 1'b1, "ovw_rel2");
    addVec(1'b0, 1'b1, 3'd6, 1'b0, 1,  1'b1, 1'b1, 3'd4, 1'b1, "ovw_n6");
    addVec(1'b0, 1'b0, 3'd6, 1'b0, 43, 1'b0, 1'b1, 3'd4, 1'b1, "ovw_gap_last");
    addVec(1'b0, 1'b0, 3'd6, 1'b0, 1,  1'b1, 1'b1, 3'd6, 1'b0, "ovw_latest");
    addVec(1'b0, 1'b0, 3'd6, 1'b0, 47, 1'b0, 1'b1, 3'd6, 1'b0, "byp_gap_last");
    addVec(1'b0, 1'b1, 3'd3, 1'b0, 1,  1'b1, 1'b1, 3'd3, 1'b0, "bypass_n3");
    addVec(1'b0, 1'b0, 3'd3, 1'b0, 1,  1'b1, 1'b1, 3'd3, 1'b0, "col_rel");
    addVec(1'b0, 1'b1, 3'd5, 1'b0, 1,  1'b1, 1'b1, 3'd3, 1'b1, "col_queue_n5");
    addVec(1'b0, 1'b0, 3'd5, 1'b0, 45, 1'b0, 1'b1, 3'd3, 1'b1, "col_gap_last");
    addVec(1'b0, 1'b1, 3'd7, 1'b0, 1,  1'b1, 1'b1, 3'd5, 1'b1, "collision");
    addVec(1'b0, 1'b0, 3'd7, 1'b0, 1,  1'b1, 1'b1, 3'd5, 1'b1, "abort_pre");
    addVec(1'b0, 1'b1, 3'd2, 1'b1, 1,  1'b0, 1'b0, 3'd5, 1'b0, "abort");
    addVec(1'b0, 1'b1, 3'd2, 1'b0, 3,  1'b0, 1'b0, 3'd5, 1'b0, "abort_no_start");
    addVec(1'b0, 1'b0, 3'd2, 1'b0, 5,  1'b0, 1'b0, 3'd5, 1'b0, "abort_idle");
    addVec(1'b0, 1'b1, 3'd0, 1'b0, 1,  1'b1, 1'b1, 3'd0, 1'b0, "press_n0");
    addVec(1'b0, 1'b1, 3'd0, 1'b0, 47, 1'b0, 1'b1, 3'd0, 1'b0, "n0_gap_last");
    addVec(1'b0, 1'b1, 3'd0, 1'b0, 1,  1'b0, 1'b0, 3'd0, 1'b0, "gap_to_idle");
    addVec(1'b0, 1'b1, 3'd0, 1'b0, 20, 1'b0, 1'b0, 3'd0, 1'b0, "held_one_note");
    addVec(1'b0, 1'b0, 3'd1, 1'b0, 1,  1'b0, 1'b0, 3'd0, 1'b0, "pre_rst_idle");
    addVec(1'b0, 1'b1, 3'd1, 1'b0, 1,  1'b1, 1'b1, 3'd1, 1'b0, "press_n1");
    addVec(1'b1, 1'b1, 3'd1, 1'b0, 1,  1'b0, 1'b0, 3'd0, 1'b0, "reset_busy");
    addVec(1'b0, 1'b1, 3'd3, 1'b0, 1,  1'b1, 1'b1, 3'd3, 1'b0, "press_at_release");

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Long instance: note 7 (half period 25800) against a 51600-cycle note,
    // so the second toggle lands on the last PLAY cycle and must be dropped.
    rst = 1'b1; btn_s = 1'b0; stop_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("long_reset", tone_l, busy_l, note_l, pend_l, 1'b0, 1'b0, 3'd0, 1'b0);
    btn_l = 1'b1; sel_l = 3'd7;
    @(posedge clk); #1;
    checkOutput("long_first_high", tone_l, busy_l, note_l, pend_l, 1'b1, 1'b1, 3'd7, 1'b0);
    repeat (25799) @(posedge clk);
    #1;
    checkOutput("long_high_end", tone_l, busy_l, note_l, pend_l, 1'b1, 1'b1, 3'd7, 1'b0);
    @(posedge clk); #1;
    checkOutput("long_fall", tone_l, busy_l, note_l, pend_l, 1'b0, 1'b1, 3'd7, 1'b0);
    repeat (25799) @(posedge clk);
    #1;
    checkOutput("long_low_end", tone_l, busy_l, note_l, pend_l, 1'b0, 1'b1, 3'd7, 1'b0);
    @(posedge clk); #1;
    checkOutput("long_toggle_dropped", tone_l, busy_l, note_l, pend_l, 1'b0, 1'b1, 3'd7, 1'b0);
    repeat (L_GAP - 1) @(posedge clk);
    #1;
    checkOutput("long_gap_last", tone_l, busy_l, note_l, pend_l, 1'b0, 1'b1, 3'd7, 1'b0);
    @(posedge clk); #1;
    checkOutput("long_idle", tone_l, busy_l, note_l, pend_l, 1'b0, 1'b0, 3'd7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
